// File: rtl/hex_byte_parser.sv
// ASCII hex character stream to binary bytes, buffered in a first-word fall-through FIFO.
// Malformed characters raise a one-cycle error pulse; dropped bytes set a sticky overflow flag.
//
// state     | meaning
// S_IDLE    | no pending nibble; next digit becomes the high nibble
// S_HAVE_HI | high nibble held in r_hi; next digit or separator completes a byte
module hex_byte_parser #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_rx_valid,
    input  logic [7:0]            i_rx_data,
    input  logic                  i_out_ready,
    output logic                  o_out_valid,
    output logic [7:0]            o_out_data,
    output logic [DEPTH_LOG2:0]   o_fifo_count,
    output logic                  o_err,
    output logic                  o_overflow
);

    localparam int DEPTH = 2 ** DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_COUNT = (DEPTH_LOG2 + 1)'(DEPTH);

    typedef enum logic {
        S_IDLE,
        S_HAVE_HI
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [3:0]              r_hi;
    logic                    r_err;
    logic                    r_overflow;

    logic                    w_is_digit;
    logic                    w_is_sep;
    logic [3:0]              w_nibble;
    logic                    w_hi_load;
    logic                    w_push;
    logic [7:0]              w_push_data;
    logic                    w_err_set;

    logic [7:0]              r_mem [DEPTH];
    logic [DEPTH_LOG2-1:0]   r_wr_ptr;
    logic [DEPTH_LOG2-1:0]   r_rd_ptr;
    logic [DEPTH_LOG2:0]     r_count;
    logic                    w_empty;
    logic                    w_full;
    logic                    w_pop;
    logic                    w_wr_en;

    always_comb begin
        w_is_digit = 1'b0;
        w_is_sep   = 1'b0;
        w_nibble   = 4'h0;
        if (i_rx_data >= 8'h30 && i_rx_data <= 8'h39) begin
            w_is_digit = 1'b1;
            w_nibble   = i_rx_data[3:0];
        end else if ((i_rx_data >= 8'h41 && i_rx_data <= 8'h46) ||
                     (i_rx_data >= 8'h61 && i_rx_data <= 8'h66)) begin
            // 'A'/'a' have low nibble 1, so adding 9 maps them to 10
            w_is_digit = 1'b1;
            w_nibble   = i_rx_data[3:0] + 4'd9;
        end else if (i_rx_data == 8'h20 || i_rx_data == 8'h0D ||
                     i_rx_data == 8'h0A || i_rx_data == 8'h2C) begin
            w_is_sep = 1'b1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_hi_load   = 1'b0;
        w_push      = 1'b0;
        w_push_data = 8'h00;
        w_err_set   = 1'b0;
        if (i_rx_valid) begin
            case (r_state)
                S_IDLE: begin
                    if (w_is_digit) begin
                        w_hi_load   = 1'b1;
                        w_state_nxt = S_HAVE_HI;
                    end else if (!w_is_sep) begin
                        w_err_set = 1'b1;
                    end
                end
                S_HAVE_HI: begin
                    w_state_nxt = S_IDLE;
                    if (w_is_digit) begin
                        w_push      = 1'b1;
                        w_push_data = {r_hi, w_nibble};
                    end else if (w_is_sep) begin
                        w_push      = 1'b1;
                        w_push_data = {4'h0, r_hi};
                    end else begin
                        w_err_set = 1'b1;
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_hi    <= 4'h0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_err   <= w_err_set;
            if (w_hi_load) begin
                r_hi <= w_nibble;
            end
        end
    end

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == FULL_COUNT);
    assign w_pop   = !w_empty && i_out_ready;
    // When full, a simultaneous pop frees the slot the write pointer targets
    assign w_wr_en = w_push && (!w_full || w_pop);

    always_ff @(posedge i_clk) begin
        if (w_wr_en && !i_rst) begin
            r_mem[r_wr_ptr] <= w_push_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_wr_en, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_push && w_full && !w_pop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign o_out_valid  = !w_empty;
    assign o_out_data   = w_empty ? 8'h00 : r_mem[r_rd_ptr];
    assign o_fifo_count = r_count;
    assign o_err        = r_err;
    assign o_overflow   = r_overflow;

endmodule

// File: tb/tb_hex_byte_parser.sv
// Scoreboard bench for hex_byte_parser: expected bytes are queued as characters are sent
// and compared in order as the FIFO is drained.
module tb_hex_byte_parser;

    logic       i_clk;
    logic       i_rst;
    logic       i_rx_valid;
    logic [7:0] i_rx_data;
    logic       i_out_ready;
    logic       o_out_valid;
    logic [7:0] o_out_data;
    logic [4:0] o_fifo_count;
    logic       o_err;
    logic       o_overflow;

    int         n_tests;
    int         n_fail;
    logic [7:0] exp_q [$];

    hex_byte_parser #(.DEPTH_LOG2(4)) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_rx_valid   (i_rx_valid),
        .i_rx_data    (i_rx_data),
        .i_out_ready  (i_out_ready),
        .o_out_valid  (o_out_valid),
        .o_out_data   (o_out_data),
        .o_fifo_count (o_fifo_count),
        .o_err        (o_err),
        .o_overflow   (o_overflow)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    function automatic logic [7:0] hexc(input logic [3:0] n, input bit lower);
        if (n < 4'd10) return 8'h30 + {4'h0, n};
        return (lower ? 8'h61 : 8'h41) + {4'h0, n} - 8'd10;
    endfunction

    task automatic cyc();
        @(posedge i_clk);
        #1;
    endtask

    task automatic send_char(input logic [7:0] c);
        i_rx_valid = 1'b1;
        i_rx_data  = c;
        cyc();
        i_rx_valid = 1'b0;
        i_rx_data  = 8'h00;
    endtask

    task automatic test_reset();
        i_rst = 1'b1;
        cyc();
        cyc();
        i_rst = 1'b0;
        exp_q.delete();
        n_tests++;
        if (o_out_valid !== 1'b0 || o_out_data !== 8'h00 || o_fifo_count !== 5'd0 ||
            o_err !== 1'b0 || o_overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: valid=%b data=%h count=%0d err=%b ovf=%b, want 0/00/0/0/0",
                     o_out_valid, o_out_data, o_fifo_count, o_err, o_overflow);
        end
    endtask

    task automatic test_single_byte();
        test_reset();
        send_char("3");
        n_tests++;
        if (o_out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL half_byte_valid: got %b want 0", o_out_valid);
        end
        send_char("F");
        n_tests++;
        if (o_out_valid !== 1'b1 || o_out_data !== 8'h3F || o_fifo_count !== 5'd1) begin
            n_fail++;
            $display("FAIL first_byte: valid=%b data=%h count=%0d want 1/3f/1",
                     o_out_valid, o_out_data, o_fifo_count);
        end
        send_char(" ");
        n_tests++;
        if (o_fifo_count !== 5'd1) begin
            n_fail++;
            $display("FAIL sep_after_byte_count: got %0d want 1", o_fifo_count);
        end
        i_out_ready = 1'b1;
        cyc();
        i_out_ready = 1'b0;
        n_tests++;
        if (o_fifo_count !== 5'd0 || o_out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL pop_single: count=%0d valid=%b want 0/0", o_fifo_count, o_out_valid);
        end
    endtask

    task automatic test_mixed_case();
        logic [7:0] str [$];
        logic [7:0] e;
        test_reset();
        str = '{"a", "0", ",", "7", 8'h0D, "A", "0", " ", "A", "B", "C", " ", "f", "E", 8'h0A};
        exp_q.push_back(8'hA0);
        exp_q.push_back(8'h07);
        exp_q.push_back(8'hA0);
        exp_q.push_back(8'hAB);
        exp_q.push_back(8'h0C);
        exp_q.push_back(8'hFE);
        foreach (str[k]) send_char(str[k]);
        i_out_ready = 1'b1;
        for (int k = 0; k < 40 && exp_q.size() > 0; k++) begin
            if (o_out_valid) begin
                e = exp_q.pop_front();
                n_tests++;
                if (o_out_data !== e) begin
                    n_fail++;
                    $display("FAIL mixed_case_data: got %h want %h", o_out_data, e);
                end
            end
            cyc();
        end
        i_out_ready = 1'b0;
        n_tests++;
        if (exp_q.size() != 0 || o_out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL mixed_case_drain: %0d bytes missing, valid=%b", exp_q.size(), o_out_valid);
        end
    endtask

    task automatic test_invalid();
        logic [7:0] e;
        test_reset();
        send_char("4");
        send_char("G");
        n_tests++;
        if (o_err !== 1'b1 || o_fifo_count !== 5'd0) begin
            n_fail++;
            $display("FAIL err_pulse: err=%b count=%0d want 1/0", o_err, o_fifo_count);
        end
        cyc();
        n_tests++;
        if (o_err !== 1'b0) begin
            n_fail++;
            $display("FAIL err_one_cycle: got %b want 0", o_err);
        end
        send_char("x");
        n_tests++;
        if (o_err !== 1'b1) begin
            n_fail++;
            $display("FAIL err_idle: got %b want 1", o_err);
        end
        send_char("1");
        send_char("2");
        exp_q.push_back(8'h12);
        n_tests++;
        if (o_err !== 1'b0) begin
            n_fail++;
            $display("FAIL err_cleared: got %b want 0", o_err);
        end
        i_out_ready = 1'b1;
        for (int k = 0; k < 10 && exp_q.size() > 0; k++) begin
            if (o_out_valid) begin
                e = exp_q.pop_front();
                n_tests++;
                if (o_out_data !== e || o_fifo_count !== 5'd1) begin
                    n_fail++;
                    $display("FAIL after_err_data: got %h count %0d want %h count 1", o_out_data, o_fifo_count, e);
                end
            end
            cyc();
        end
        i_out_ready = 1'b0;
    endtask

    task automatic test_overflow();
        logic [7:0] b;
        logic [7:0] e;
        test_reset();
        i_out_ready = 1'b0;
        for (int i = 0; i <= 16; i++) begin
            b = 8'(i);
            send_char(hexc(b[7:4], 1'b0));
            send_char(hexc(b[3:0], 1'b1));
            if (i < 16) exp_q.push_back(b);
            if (i == 15) begin
                n_tests++;
                if (o_fifo_count !== 5'd16 || o_overflow !== 1'b0) begin
                    n_fail++;
                    $display("FAIL fill_16: count=%0d ovf=%b want 16/0", o_fifo_count, o_overflow);
                end
            end
        end
        n_tests++;
        if (o_fifo_count !== 5'd16 || o_overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL overflow_17: count=%0d ovf=%b want 16/1", o_fifo_count, o_overflow);
        end
        i_out_ready = 1'b1;
        for (int k = 0; k < 40 && exp_q.size() > 0; k++) begin
            if (o_out_valid) begin
                e = exp_q.pop_front();
                n_tests++;
                if (o_out_data !== e) begin
                    n_fail++;
                    $display("FAIL overflow_drain: got %h want %h", o_out_data, e);
                end
            end
            cyc();
        end
        i_out_ready = 1'b0;
        n_tests++;
        if (exp_q.size() != 0 || o_out_valid !== 1'b0 || o_overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL overflow_end: left=%0d valid=%b ovf=%b want 0/0/1",
                     exp_q.size(), o_out_valid, o_overflow);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] b;
        logic [7:0] e;
        test_reset();
        for (int i = 0; i < 16; i++) begin
            b = 8'h20 + 8'(i);
            send_char(hexc(b[7:4], 1'b0));
            send_char(hexc(b[3:0], 1'b0));
            exp_q.push_back(b);
        end
        for (int i = 0; i < 20; i++) begin
            b = 8'h40 + 8'(i);
            send_char(hexc(b[7:4], 1'b0));
            i_out_ready = 1'b1;
            e = exp_q.pop_front();
            n_tests++;
            if (o_out_data !== e) begin
                n_fail++;
                $display("FAIL full_pushpop_data: got %h want %h", o_out_data, e);
            end
            exp_q.push_back(b);
            send_char(hexc(b[3:0], 1'b1));
            i_out_ready = 1'b0;
            n_tests++;
            if (o_fifo_count !== 5'd16 || o_overflow !== 1'b0) begin
                n_fail++;
                $display("FAIL full_pushpop_count: count=%0d ovf=%b want 16/0", o_fifo_count, o_overflow);
            end
        end
        i_out_ready = 1'b1;
        for (int k = 0; k < 40 && exp_q.size() > 0; k++) begin
            if (o_out_valid) begin
                e = exp_q.pop_front();
                n_tests++;
                if (o_out_data !== e) begin
                    n_fail++;
                    $display("FAIL wrap_drain: got %h want %h", o_out_data, e);
                end
            end
            cyc();
        end
        i_out_ready = 1'b0;
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL wrap_drain_timeout: %0d bytes missing", exp_q.size());
        end
    endtask

    task automatic test_mid_reset();
        logic [7:0] e;
        test_reset();
        send_char("9");
        send_char("Z");
        send_char("5");
        i_rst      = 1'b1;
        i_rx_valid = 1'b1;
        i_rx_data  = "7";
        cyc();
        i_rst      = 1'b0;
        i_rx_valid = 1'b0;
        i_rx_data  = 8'h00;
        n_tests++;
        if (o_overflow !== 1'b0 || o_err !== 1'b0 || o_fifo_count !== 5'd0 || o_out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset_state: ovf=%b err=%b count=%0d valid=%b want all 0",
                     o_overflow, o_err, o_fifo_count, o_out_valid);
        end
        send_char("6");
        send_char(" ");
        exp_q.push_back(8'h06);
        i_out_ready = 1'b1;
        for (int k = 0; k < 10 && exp_q.size() > 0; k++) begin
            if (o_out_valid) begin
                e = exp_q.pop_front();
                n_tests++;
                if (o_out_data !== e) begin
                    n_fail++;
                    $display("FAIL mid_reset_data: got %h want %h", o_out_data, e);
                end
            end
            cyc();
        end
        i_out_ready = 1'b0;
        n_tests++;
        if (exp_q.size() != 0 || o_out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset_drain: left=%0d valid=%b want 0/0", exp_q.size(), o_out_valid);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_tests     = 0;
        n_fail      = 0;
        i_rst       = 1'b1;
        i_rx_valid  = 1'b0;
        i_rx_data   = 8'h00;
        i_out_ready = 1'b0;
        cyc();
        test_reset();
        test_single_byte();
        test_mixed_case();
        test_invalid();
        test_overflow();
        test_back_to_back();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
